// File: rtl/gpu_console_pkg.sv
// gpu_console_pkg: shared constants, control codes, state encoding and
// cursor op codes for the text-mode console writer.
package gpu_console_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 30;
    localparam int SCREEN_CELLS = COLS * ROWS;

    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0] PR_LO = 8'h20;
    localparam logic [7:0] PR_HI = 8'h7E;

    localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
    localparam logic [11:0] CLR_ROW_LAST = 12'(COLS - 1);
    localparam logic [11:0] CLR_ALL_LAST = 12'(SCREEN_CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLR_ROW,
        S_CLR_ALL
    } state_t;

    // Cursor operations applied on the next clock edge
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADV  = 3'd1;
    localparam logic [2:0] OP_NL   = 3'd2;
    localparam logic [2:0] OP_HOME = 3'd3;
    localparam logic [2:0] OP_BACK = 3'd4;
    localparam logic [2:0] OP_CR   = 3'd5;

    // row*80 + col using shifts only; result always < 2400 for legal inputs
    function automatic logic [11:0] cell_addr(input logic [4:0] r,
                                              input logic [6:0] c);
        return ({7'd0, r} << 6) + ({7'd0, r} << 4) + {5'd0, c};
    endfunction

endpackage

// File: rtl/gpu_console_cursor.sv
// gpu_console_cursor: 80x30 cursor registers and linear cell address.
// Ports: clk, rst, op (cursor op code) -> col, row, row_next,
//        wrap_to_new_row (advance would leave the row), addr (row*80+col).
module gpu_console_cursor
    import gpu_console_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    output logic [6:0]  col,
    output logic [4:0]  row,
    output logic [4:0]  row_next,
    output logic        wrap_to_new_row,
    output logic [11:0] addr
);

    // No scrolling: the row after the last one is row 0
    assign row_next        = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    assign wrap_to_new_row = (col == LAST_COL);
    assign addr            = cell_addr(row, col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= 7'd0;
            row <= 5'd0;
        end else begin
            case (op)
                OP_ADV: begin
                    if (wrap_to_new_row) begin
                        col <= 7'd0;
                        row <= row_next;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
                OP_NL: begin
                    col <= 7'd0;
                    row <= row_next;
                end
                OP_HOME: begin
                    col <= 7'd0;
                    row <= 5'd0;
                end
                OP_BACK: begin
                    if (col != 7'd0) col <= col - 7'd1;
                end
                OP_CR: col <= 7'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gpu_console.sv
// gpu_console: byte-stream to text RAM writer with CR/LF/BS/FF handling.
// Ports: clk, rst, char_in/char_valid/char_ready (byte handshake),
//        write_address/data_out/w_en (registered RAM write), cursor_col,
//        cursor_row, busy.
module gpu_console
    import gpu_console_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [11:0] write_address,
    output logic [7:0]  data_out,
    output logic        w_en,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    state_t      state;
    logic [11:0] clr_cnt;
    logic        adv_pending;
    logic [2:0]  op;
    logic [4:0]  row_next;
    logic        wrap;
    logic [11:0] cur_addr;

    logic accept;
    logic is_print;
    logic is_lf;
    logic is_ff;
    logic is_bs_move;
    logic is_cr;

    assign char_ready = !busy && !rst;
    assign accept     = char_valid && char_ready;

    assign is_print   = (char_in >= PR_LO) && (char_in <= PR_HI);
    assign is_lf      = (char_in == CH_LF);
    assign is_ff      = (char_in == CH_FF);
    assign is_cr      = (char_in == CH_CR);
    // Backspace at column 0 falls through as an ignored byte
    assign is_bs_move = (char_in == CH_BS) && (cursor_col != 7'd0);

    gpu_console_cursor u_cursor (
        .clk             (clk),
        .rst             (rst),
        .op              (op),
        .col             (cursor_col),
        .row             (cursor_row),
        .row_next        (row_next),
        .wrap_to_new_row (wrap),
        .addr            (cur_addr)
    );

    // Printables move the cursor one cycle late, after their write is out
    always_comb begin
        op = OP_NONE;
        if (state == S_IDLE && accept) begin
            if (is_lf)           op = OP_NL;
            else if (is_ff)      op = OP_HOME;
            else if (is_bs_move) op = OP_BACK;
            else if (is_cr)      op = OP_CR;
        end else if (state == S_WRITE && adv_pending) begin
            op = OP_ADV;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            w_en          <= 1'b0;
            write_address <= 12'd0;
            data_out      <= 8'd0;
            busy          <= 1'b0;
            clr_cnt       <= 12'd0;
            adv_pending   <= 1'b0;
        end else begin
            w_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_print: begin
                                w_en          <= 1'b1;
                                write_address <= cur_addr;
                                data_out      <= char_in;
                                adv_pending   <= 1'b1;
                                busy          <= 1'b1;
                                state         <= S_WRITE;
                            end
                            is_lf: begin
                                w_en          <= 1'b1;
                                write_address <= cell_addr(row_next, 7'd0);
                                data_out      <= BLANK;
                                clr_cnt       <= 12'd0;
                                busy          <= 1'b1;
                                state         <= S_CLR_ROW;
                            end
                            is_ff: begin
                                w_en          <= 1'b1;
                                write_address <= 12'd0;
                                data_out      <= BLANK;
                                clr_cnt       <= 12'd0;
                                busy          <= 1'b1;
                                state         <= S_CLR_ALL;
                            end
                            is_bs_move: begin
                                w_en          <= 1'b1;
                                write_address <= cur_addr - 12'd1;
                                data_out      <= BLANK;
                                adv_pending   <= 1'b0;
                                busy          <= 1'b1;
                                state         <= S_WRITE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    adv_pending <= 1'b0;
                    if (adv_pending && wrap) begin
                        w_en          <= 1'b1;
                        write_address <= cell_addr(row_next, 7'd0);
                        data_out      <= BLANK;
                        clr_cnt       <= 12'd0;
                        state         <= S_CLR_ROW;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_CLR_ROW: begin
                    if (clr_cnt == CLR_ROW_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        w_en          <= 1'b1;
                        write_address <= write_address + 12'd1;
                        clr_cnt       <= clr_cnt + 12'd1;
                    end
                end
                S_CLR_ALL: begin
                    if (clr_cnt == CLR_ALL_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        w_en          <= 1'b1;
                        write_address <= write_address + 12'd1;
                        clr_cnt       <= clr_cnt + 12'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
